// File: rtl/adf4351_pkg.sv
// Shared constants, register addresses and FSM encoding for the ADF4351
// programming-interface receiver.
package adf4351_pkg;

  localparam int ADF_WORD_W   = 32;
  localparam int ADF_NUM_REGS = 6;
  localparam int ADF_ADDR_W   = 3;
  localparam int ADF_DATA_W   = 29;

  localparam logic [ADF_ADDR_W-1:0] R0 = 3'd0;
  localparam logic [ADF_ADDR_W-1:0] R1 = 3'd1;
  localparam logic [ADF_ADDR_W-1:0] R2 = 3'd2;
  localparam logic [ADF_ADDR_W-1:0] R3 = 3'd3;
  localparam logic [ADF_ADDR_W-1:0] R4 = 3'd4;
  localparam logic [ADF_ADDR_W-1:0] R5 = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010,
    S_LATCH = 3'b100
  } state_t;

endpackage

// File: rtl/adf4351_spi_rx_if.sv
// Serial pins in, committed-word event stream out.
interface adf4351_spi_rx_if;
  import adf4351_pkg::*;

  logic                  spi_clk;
  logic                  spi_data;
  logic                  spi_le;
  logic                  wr_valid;
  logic [ADF_ADDR_W-1:0] wr_addr;
  logic [ADF_DATA_W-1:0] wr_data;
  logic                  err_len;
  logic                  err_addr;

  // wr_valid/err_len/err_addr are single-cycle pulses with no ready: the
  // receiver cannot be stalled, so a listener must accept every pulse.
  // wr_addr/wr_data hold the last committed word between pulses.
  modport slave (
    input  spi_clk, spi_data, spi_le,
    output wr_valid, wr_addr, wr_data, err_len, err_addr
  );

  modport master (
    output spi_clk, spi_data, spi_le,
    input  wr_valid, wr_addr, wr_data, err_len, err_addr
  );
endinterface

// File: rtl/adf_sync_edge.sv
// Multi-flop synchroniser followed by a one-flop rise/fall detector.
module adf_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise =  q & ~prev_q;
  assign fall = ~q &  prev_q;

endmodule

// File: rtl/adf4351_spi_rx.sv
// ADF4351 CLK/DATA/LE receiver: deserialises 32-bit words and keeps a
// shadow copy of R0..R5.
module adf4351_spi_rx
  import adf4351_pkg::*;
#(
  parameter int WORD_W      = ADF_WORD_W,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = ADF_NUM_REGS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  adf4351_spi_rx_if.slave         bus,
  output logic [ADF_DATA_W-1:0]   reg0,
  output logic [ADF_DATA_W-1:0]   reg1,
  output logic [ADF_DATA_W-1:0]   reg2,
  output logic [ADF_DATA_W-1:0]   reg3,
  output logic [ADF_DATA_W-1:0]   reg4,
  output logic [ADF_DATA_W-1:0]   reg5,
  output logic [ADF_NUM_REGS-1:0] reg_valid_mask,
  output state_t                  fsm_state
);

  logic clk_s, clk_rise, clk_fall;
  logic data_s, data_rise, data_fall;
  logic le_s, le_rise, le_fall;

  adf_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .d(bus.spi_clk),
    .q(clk_s), .rise(clk_rise), .fall(clk_fall)
  );

  // Data takes the same path length as spi_clk so the bit seen with clk_rise
  // is the one present at the pin edge.
  adf_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .d(bus.spi_data),
    .q(data_s), .rise(data_rise), .fall(data_fall)
  );

  adf_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_le (
    .clk(clk), .rst_n(rst_n), .d(bus.spi_le),
    .q(le_s), .rise(le_rise), .fall(le_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, clk_s, clk_fall, data_rise, data_fall, le_s};

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (le_fall) state_d = S_SHIFT;
      S_SHIFT: if (le_rise) state_d = S_LATCH;
      S_LATCH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign fsm_state = state_q;

  logic [WORD_W-1:0]      shift_q;
  logic [5:0]             bit_cnt;
  logic [ADF_DATA_W-1:0]  bank_q [ADF_NUM_REGS];
  logic [ADF_NUM_REGS-1:0] mask_q;
  logic [ADF_ADDR_W-1:0]  word_addr;

  assign word_addr = shift_q[ADF_ADDR_W-1:0];

  // The commit is registered on the edge that enters LATCH, so the pulses and
  // the updated bank are visible for exactly the LATCH cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_q      <= '0;
      bit_cnt      <= '0;
      mask_q       <= '0;
      bus.wr_valid <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.err_len  <= 1'b0;
      bus.err_addr <= 1'b0;
      for (int i = 0; i < ADF_NUM_REGS; i++) bank_q[i] <= '0;
    end else begin
      bus.wr_valid <= 1'b0;
      bus.err_len  <= 1'b0;
      bus.err_addr <= 1'b0;
      if (state_q == S_IDLE && le_fall) begin
        bit_cnt <= '0;
      end else if (state_q == S_SHIFT) begin
        if (le_rise) begin
          if (int'(bit_cnt) < WORD_W) begin
            bus.err_len <= 1'b1;
          end else if (int'(word_addr) < NUM_REGS) begin
            bank_q[word_addr] <= shift_q[WORD_W-1:ADF_ADDR_W];
            mask_q[word_addr] <= 1'b1;
            bus.wr_valid      <= 1'b1;
            bus.wr_addr       <= word_addr;
            bus.wr_data       <= shift_q[WORD_W-1:ADF_ADDR_W];
          end else begin
            bus.err_addr <= 1'b1;
          end
        end else if (clk_rise) begin
          shift_q <= {shift_q[WORD_W-2:0], data_s};
          if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
        end
      end
    end
  end

  assign reg0 = bank_q[0];
  assign reg1 = bank_q[1];
  assign reg2 = bank_q[2];
  assign reg3 = bank_q[3];
  assign reg4 = bank_q[4];
  assign reg5 = bank_q[5];
  assign reg_valid_mask = mask_q;

endmodule

// File: tb/tb_adf4351_spi_rx.sv
// Directed bench for adf4351_spi_rx: drives the 3-wire bus at clk/6 and
// checks committed words, error pulses and the shadow bank.
module tb_adf4351_spi_rx;
  import adf4351_pkg::*;

  logic clk;
  logic rst_n;
  adf4351_spi_rx_if bus ();

  logic [28:0] reg0, reg1, reg2, reg3, reg4, reg5;
  logic [5:0]  reg_valid_mask;
  state_t      fsm_state;

  adf4351_spi_rx dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4), .reg5(reg5),
    .reg_valid_mask(reg_valid_mask), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int wv_cnt = 0;
  int el_cnt = 0;
  int ea_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [28:0] reg_obs [6];

  always_comb begin
    reg_obs[0] = reg0; reg_obs[1] = reg1; reg_obs[2] = reg2;
    reg_obs[3] = reg3; reg_obs[4] = reg4; reg_obs[5] = reg5;
  end

  // monitor: collect committed words and pulse counts away from the edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_valid) begin
        got_q.push_back({bus.wr_data, bus.wr_addr});
        wv_cnt++;
      end
      if (bus.err_len)  el_cnt++;
      if (bus.err_addr) ea_cnt++;
      if (bus.wr_valid | bus.err_len | bus.err_addr) begin
        checks++;
        if ($countones({bus.wr_valid, bus.err_len, bus.err_addr}) > 1) begin
          errors++;
          $display("FAIL pulse_exclusive: got %b required at most one set",
                   {bus.wr_valid, bus.err_len, bus.err_addr});
        end
      end
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic shift_bits(input logic [63:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.spi_data = bits[i];
      bus.spi_clk  = 1'b0;
      wait_clk(3);
      bus.spi_clk  = 1'b1;
      wait_clk(3);
    end
  endtask

  task automatic le_low();
    bus.spi_le = 1'b0;
    wait_clk(4);
  endtask

  task automatic le_high();
    bus.spi_clk = 1'b0;
    wait_clk(3);
    bus.spi_le = 1'b1;
    wait_clk(10);
  endtask

  task automatic send_word(input logic [63:0] bits, input int n);
    le_low();
    shift_bits(bits, n);
    le_high();
  endtask

  task automatic check_scoreboard(input string name);
    logic [31:0] exp_w;
    logic [31:0] got_w;
    while (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL %s_word: got nothing required %h", name, exp_w);
      end else begin
        got_w = got_q.pop_front();
        if (got_w !== exp_w) begin
          errors++;
          $display("FAIL %s_word: got %h required %h", name, got_w, exp_w);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL %s_extra: got %0d unexpected words required 0", name, got_q.size());
      got_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.spi_clk = 1'b0; bus.spi_data = 1'b0; bus.spi_le = 1'b1;
    rst_n = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    checks++;
    if (fsm_state !== S_IDLE) begin
      errors++; $display("FAIL reset_state: got %b required %b", fsm_state, S_IDLE);
    end
    checks++;
    if (reg_valid_mask !== 6'h00) begin
      errors++; $display("FAIL reset_mask: got %h required 00", reg_valid_mask);
    end
    checks++;
    if ({bus.wr_valid, bus.err_len, bus.err_addr} !== 3'b000) begin
      errors++; $display("FAIL reset_pulses: got %b required 000", {bus.wr_valid, bus.err_len, bus.err_addr});
    end
    checks++;
    if ({bus.wr_addr, bus.wr_data} !== 32'h0) begin
      errors++; $display("FAIL reset_wr_bus: got %h required 0", {bus.wr_data, bus.wr_addr});
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (reg_obs[i] !== 29'h0) begin
        errors++; $display("FAIL reset_reg%0d: got %h required 0", i, reg_obs[i]);
      end
    end
  endtask

  task automatic test_single_word();
    int wv0 = wv_cnt;
    exp_q.push_back(32'h00580005);
    send_word({32'h0, 32'h00580005}, 32);
    checks++;
    if (wv_cnt - wv0 != 1) begin
      errors++; $display("FAIL single_wr_valid_count: got %0d required 1", wv_cnt - wv0);
    end
    check_scoreboard("single");
    checks++;
    if (reg5 !== 29'h000B0000) begin
      errors++; $display("FAIL single_reg5: got %h required 000b0000", reg5);
    end
    checks++;
    if (reg_valid_mask !== 6'h20) begin
      errors++; $display("FAIL single_mask: got %h required 20", reg_valid_mask);
    end
    checks++;
    if (bus.wr_addr !== 3'd5 || bus.wr_data !== 29'h000B0000) begin
      errors++; $display("FAIL single_wr_hold: got %h/%h required 5/000b0000", bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [6];
    logic [28:0] exp_reg [6];
    int wv0 = wv_cnt;
    words = '{32'h00580005, 32'h008C803C, 32'h000004B3,
              32'h00004E42, 32'h08008011, 32'h00300000};
    exp_reg = '{29'h00060000, 29'h01001002, 29'h000009C8,
                29'h00000096, 29'h00119007, 29'h000B0000};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(words[i]);
      send_word({32'h0, words[i]}, 32);
    end
    checks++;
    if (wv_cnt - wv0 != 6) begin
      errors++; $display("FAIL b2b_wr_valid_count: got %0d required 6", wv_cnt - wv0);
    end
    check_scoreboard("b2b");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (reg_obs[i] !== exp_reg[i]) begin
        errors++; $display("FAIL b2b_reg%0d: got %h required %h", i, reg_obs[i], exp_reg[i]);
      end
    end
    checks++;
    if (reg_valid_mask !== 6'h3F) begin
      errors++; $display("FAIL b2b_mask: got %h required 3f", reg_valid_mask);
    end
  endtask

  task automatic test_short_word();
    int wv0 = wv_cnt;
    int el0 = el_cnt;
    send_word({44'h0, 20'hABCDE}, 20);
    checks++;
    if (el_cnt - el0 != 1) begin
      errors++; $display("FAIL short_err_len: got %0d required 1", el_cnt - el0);
    end
    checks++;
    if (wv_cnt != wv0) begin
      errors++; $display("FAIL short_no_write: got %0d writes required 0", wv_cnt - wv0);
    end
    checks++;
    if (reg0 !== 29'h00060000 || reg4 !== 29'h00119007) begin
      errors++; $display("FAIL short_bank: got %h/%h required 00060000/00119007", reg0, reg4);
    end
    checks++;
    if (reg_valid_mask !== 6'h3F) begin
      errors++; $display("FAIL short_mask: got %h required 3f", reg_valid_mask);
    end
  endtask

  task automatic test_bad_addr();
    int wv0 = wv_cnt;
    int ea0 = ea_cnt;
    send_word({32'h0, 32'h12345676}, 32);
    checks++;
    if (ea_cnt - ea0 != 1) begin
      errors++; $display("FAIL addr6_err_addr: got %0d required 1", ea_cnt - ea0);
    end
    checks++;
    if (wv_cnt != wv0) begin
      errors++; $display("FAIL addr6_no_write: got %0d writes required 0", wv_cnt - wv0);
    end
    checks++;
    if (reg0 !== 29'h00060000 || reg5 !== 29'h000B0000) begin
      errors++; $display("FAIL addr6_bank: got %h/%h required 00060000/000b0000", reg0, reg5);
    end
    // 40 bits: only the last 32 count
    exp_q.push_back(32'h00580005);
    send_word({24'h0, 8'hAB, 32'h00580005}, 40);
    check_scoreboard("long");
    checks++;
    if (reg5 !== 29'h000B0000) begin
      errors++; $display("FAIL long_reg5: got %h required 000b0000", reg5);
    end
  endtask

  task automatic test_le_wins();
    int wv0 = wv_cnt;
    int el0 = el_cnt;
    bus.spi_le = 1'b1;
    shift_bits({54'h0, 10'h3FF}, 10);
    bus.spi_clk = 1'b0;
    wait_clk(3);
    le_low();
    shift_bits({33'h0, 31'h7FFFFFFF}, 31);
    bus.spi_data = 1'b1;
    bus.spi_clk  = 1'b0;
    wait_clk(3);
    bus.spi_le  = 1'b1;
    bus.spi_clk = 1'b1;
    wait_clk(10);
    bus.spi_clk = 1'b0;
    wait_clk(3);
    checks++;
    if (el_cnt - el0 != 1) begin
      errors++; $display("FAIL lewins_err_len: got %0d required 1", el_cnt - el0);
    end
    checks++;
    if (wv_cnt != wv0) begin
      errors++; $display("FAIL lewins_no_write: got %0d writes required 0", wv_cnt - wv0);
    end
  endtask

  task automatic test_reset_mid_word();
    int el0;
    le_low();
    shift_bits({32'h0, 32'h00300000}, 16);
    bus.spi_clk = 1'b0;
    rst_n = 1'b0;
    wait_clk(3);
    checks++;
    if (reg_valid_mask !== 6'h00 || reg5 !== 29'h0 || reg0 !== 29'h0) begin
      errors++; $display("FAIL midrst_clear: got mask %h reg0 %h reg5 %h required 0", reg_valid_mask, reg0, reg5);
    end
    checks++;
    if ({bus.wr_valid, bus.err_len, bus.err_addr, bus.wr_addr, bus.wr_data} !== 35'h0) begin
      errors++; $display("FAIL midrst_outputs: got %h required 0",
                         {bus.wr_valid, bus.err_len, bus.err_addr, bus.wr_addr, bus.wr_data});
    end
    el0 = el_cnt;
    rst_n = 1'b1;
    wait_clk(6);
    le_high();
    checks++;
    if (el_cnt - el0 != 1) begin
      errors++; $display("FAIL midrst_err_len: got %0d required 1", el_cnt - el0);
    end
    exp_q.push_back(32'h00580005);
    send_word({32'h0, 32'h00580005}, 32);
    check_scoreboard("midrst");
    checks++;
    if (reg5 !== 29'h000B0000 || reg_valid_mask !== 6'h20) begin
      errors++; $display("FAIL midrst_next_word: got %h/%h required 000b0000/20", reg5, reg_valid_mask);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_short_word();
    test_bad_addr();
    test_le_wins();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
